mult_operand_sequencer: RTL
===========================

// Module: mult_operand_sequencer
// PURPOSE
//  Feeds shift_and_add_binary_multiplier from a stream of operand pairs and returns products.
//  Buffers pairs in a small FIFO, issues one pair at a time (load pulse + held operands),
//  waits the multiplier's fixed latency, captures the product and presents it on a
//  valid/ready output. Sits directly upstream of the multiplier and owns its load/reset.
// PARAMETERS
//  M           8  width of operand A
//  N           8  width of operand B (product is M+N bits)
//  FIFO_DEPTH  4  operand-pair FIFO entries (power of 2, >=2)
//  MUL_LATENCY 8  cycles from mul_load deasserting to mul_c being valid (>=1)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand pair on in_a/in_b is valid
//  in_ready   out  1      FIFO can accept a pair this cycle
//  in_a       in   M      operand A
//  in_b       in   N      operand B
//  mul_load   out  1      one-cycle pulse to multiplier: load/restart with mul_a/mul_b
//  mul_a      out  M      operand A to multiplier, held stable from load until capture
//  mul_b      out  N      operand B to multiplier, held stable from load until capture
//  mul_c      in   M+N    product from multiplier
//  out_valid  out  1      out_c holds a captured product
//  out_ready  in   1      consumer accepts out_c
//  out_c      out  M+N    captured product
//  busy       out  1      high when state != IDLE or FIFO not empty
//  fifo_count out  clog2(FIFO_DEPTH)+1  pairs currently buffered
// BEHAVIOUR
//  Reset (async, any state): FIFO emptied, state IDLE, all outputs 0 except in_ready=1.
//  FIFO: push when in_valid && in_ready; in_ready = !full (registered count only; a pop in the
//   same cycle does not raise in_ready). Pointers wrap modulo FIFO_DEPTH. Push and pop in the
//   same cycle leave fifo_count unchanged.
//  FSM states IDLE, LOAD, WAIT, HOLD:
//   IDLE: FIFO non-empty -> LOAD next cycle.
//   LOAD: mul_load=1 for exactly this cycle; mul_a/mul_b driven from FIFO head and registered;
//    FIFO pops; cycle counter set to MUL_LATENCY; -> WAIT.
//   WAIT: counter decrements each cycle; mul_load=0; at counter==1 mul_c is registered into
//    out_c, out_valid set -> HOLD. Capture occurs MUL_LATENCY cycles after the LOAD cycle.
//   HOLD: out_valid=1, out_c stable. On out_valid && out_ready: out_valid clears next edge;
//    -> LOAD if FIFO non-empty (after this cycle's push), else IDLE.
//  Throughput: one product per MUL_LATENCY+2 cycles with out_ready held high.
//  mul_a/mul_b keep last issued values in IDLE/HOLD (no toggling when idle).
//  No pair is dropped or duplicated; products leave in input order.
//  Width: out_c is exactly M+N bits, no truncation; operands are unsigned.
//  Reset mid-WAIT/HOLD discards in-flight and buffered pairs; no out_valid after release
//   until a new pair completes.
// TESTING
//  1 Reset: assert rst mid-cycle -> all outputs 0, in_ready=1 immediately (async).
//  2 Single pair A=8'hFF,B=8'hFF -> one mul_load pulse; out_c=16'hFE01, out_valid exactly
//    MUL_LATENCY cycles after LOAD cycle.
//  3 Burst of 5 pairs (1x1,3x2,31x31,255x1,0x77), out_ready=0 -> in_ready falls after 4th
//    accepted (one in flight frees a slot, 5th then accepted); on out_ready=1 products
//    1,6,961,255,0 emerge in order.
//  4 Backpressure: hold out_ready=0 for 20 cycles in HOLD -> out_c stable, no new mul_load.
//  5 Full FIFO with simultaneous push and pop -> push refused, fifo_count decrements by 1.
//  6 rst pulse during WAIT with 3 pairs queued -> fifo_count=0, out_valid stays 0 afterwards.

Source files
------------

// File: rtl/mult_operand_sequencer.sv
// Operand-pair FIFO and issue sequencer for a fixed-latency multiplier.
// Issues one pair per load pulse, waits the latency, presents the product.
module mult_operand_sequencer #(
  parameter int M           = 8,
  parameter int N           = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int MUL_LATENCY = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [M-1:0]                  in_a,
  input  logic [N-1:0]                  in_b,
  output logic                          mul_load,
  output logic [M-1:0]                  mul_a,
  output logic [N-1:0]                  mul_b,
  input  logic [M+N-1:0]                mul_c,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [M+N-1:0]                out_c,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(MUL_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [M+N-1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic              mul_load_q, mul_load_d;
  logic [M-1:0]      mul_a_q, mul_a_d;
  logic [N-1:0]      mul_b_q, mul_b_d;
  logic              out_valid_q, out_valid_d;
  logic [M+N-1:0]    out_c_q, out_c_d;
  logic              push, pop;
  logic [M+N-1:0]    head;

  assign in_ready   = (cnt_q != CW'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = (state_q == LOAD);
  assign head       = mem_q[rd_q];
  assign busy       = (state_q != IDLE) || (cnt_q != '0);
  assign fifo_count = cnt_q;
  assign mul_load   = mul_load_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign out_valid  = out_valid_q;
  assign out_c      = out_c_q;

  always_comb begin
    wr_d        = push ? wr_q + 1'b1 : wr_q;
    rd_d        = pop ? rd_q + 1'b1 : rd_q;
    cnt_d       = cnt_q + CW'(push) - CW'(pop);
    state_d     = state_q;
    lat_d       = lat_q;
    mul_load_d  = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    out_valid_d = out_valid_q;
    out_c_d     = out_c_q;
    unique case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          state_d            = LOAD;
          mul_load_d         = 1'b1;
          {mul_a_d, mul_b_d} = head;
        end
      end
      LOAD: begin
        state_d = WAIT;
        lat_d   = LW'(MUL_LATENCY);
      end
      WAIT: begin
        lat_d = lat_q - 1'b1;
        if (lat_q == LW'(1)) begin
          out_c_d     = mul_c;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          if (cnt_d != '0) begin
            state_d    = LOAD;
            mul_load_d = 1'b1;
            // an empty FIFO being written this cycle has no readable head yet
            if (cnt_q == '0) {mul_a_d, mul_b_d} = {in_a, in_b};
            else             {mul_a_d, mul_b_d} = head;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {in_a, in_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      lat_q       <= '0;
      mul_load_q  <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_c_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
      mul_load_q  <= mul_load_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      out_valid_q <= out_valid_d;
      out_c_q     <= out_c_d;
    end
  end

endmodule
